// File: rtl/prog_loader_16x1024.sv
// Byte-stream program loader for a 16x1024 program RAM: length, then words (low byte first).
// Optional trailing checksum check is compiled in with `define LOADER_CHECKSUM_EN.
module prog_loader_16x1024 #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_din,
    output logic              start,
    output logic              busy,
    output logic              error
);

    localparam int unsigned IDX_W = ADDR_W + 1;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WRITE, DONE, ERR, CSUM_LO, CSUM_HI, CHECK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WRITE, DONE, ERR
    } state_t;
`endif

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [15:0]       len, len_next;
    logic [7:0]        lo_byte, lo_byte_next;
    logic              we_next;
    logic [ADDR_W-1:0] addr_next;
    logic [15:0]       din_next;
    logic              accept;
    logic [15:0]       n_rx;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]       sum, sum_next;
    logic [15:0]       csum, csum_next;
`endif

    // State and datapath registers; all outputs are registered decodes of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            len          <= '0;
            lo_byte      <= '0;
            in_ready     <= 1'b0;
            ram_write_en <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
            start        <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum          <= '0;
            csum         <= '0;
`endif
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            len          <= len_next;
            lo_byte      <= lo_byte_next;
            ram_write_en <= we_next;
            ram_addr     <= addr_next;
            ram_din      <= din_next;
            in_ready     <= (state_next == LEN_LO) || (state_next == LEN_HI) ||
`ifdef LOADER_CHECKSUM_EN
                            (state_next == CSUM_LO) || (state_next == CSUM_HI) ||
`endif
                            (state_next == DAT_LO) || (state_next == DAT_HI);
            start        <= (state_next == DONE);
            error        <= (state_next == ERR);
            busy         <= !((state_next == IDLE) || (state_next == DONE) || (state_next == ERR));
`ifdef LOADER_CHECKSUM_EN
            sum          <= sum_next;
            csum         <= csum_next;
`endif
        end
    end

    assign accept = in_valid && in_ready;
    assign n_rx   = {in_data, len[7:0]};

    // Next-state and datapath update; load from any state restarts the sequence
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        len_next     = len;
        lo_byte_next = lo_byte;
        we_next      = 1'b0;
        addr_next    = ram_addr;
        din_next     = ram_din;
`ifdef LOADER_CHECKSUM_EN
        sum_next     = sum;
        csum_next    = csum;
`endif
        if (load) begin
            state_next = LEN_LO;
            idx_next   = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_next   = '0;
`endif
        end else begin
            case (state)
                LEN_LO: if (accept) begin
                    len_next[7:0] = in_data;
                    state_next    = LEN_HI;
                end
                LEN_HI: if (accept) begin
                    len_next = n_rx;
                    if ((n_rx == 16'd0) || (32'(n_rx) > MAX_WORDS)) state_next = ERR;
                    else                                            state_next = DAT_LO;
                end
                DAT_LO: if (accept) begin
                    lo_byte_next = in_data;
                    state_next   = DAT_HI;
                end
                DAT_HI: if (accept) begin
                    we_next    = 1'b1;
                    addr_next  = idx[ADDR_W-1:0];
                    din_next   = {in_data, lo_byte};
                    state_next = WRITE;
`ifdef LOADER_CHECKSUM_EN
                    sum_next   = sum + {in_data, lo_byte};
`endif
                end
                WRITE: begin
                    idx_next = idx + IDX_W'(1);
                    if ((32'(idx) + 32'd1) < 32'(len)) state_next = DAT_LO;
`ifdef LOADER_CHECKSUM_EN
                    else                               state_next = CSUM_LO;
`else
                    else                               state_next = DONE;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM_LO: if (accept) begin
                    csum_next[7:0] = in_data;
                    state_next     = CSUM_HI;
                end
                CSUM_HI: if (accept) begin
                    csum_next[15:8] = in_data;
                    state_next      = CHECK;
                end
                CHECK: state_next = (csum == sum) ? DONE : ERR;
`endif
                default: state_next = state;
            endcase
        end
    end

endmodule
